// File: rtl/mem_if_pkg.sv
// Shared definitions for the byte-wide memory bridges: state encoding,
// word geometry and the big-endian lane mapping.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAPT = 2'd2,
        ACK  = 2'd3
    } bridge_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Byte k of a word lives in lane 3-k: byte 0 is the most significant lane.
    function automatic logic [1:0] lane(input logic [1:0] k);
        return 2'd3 - k;
    endfunction

endpackage

// File: rtl/wb_mem_bridge.sv
// Splits one 32-bit Wishbone classic access into four byte accesses on a
// synchronous byte-wide memory and reassembles reads into a big-endian word.
module wb_mem_bridge
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [7:0]        mem_dat_o,
    input  logic [7:0]        mem_dat_i,
    output logic              mem_we,
    output logic              mem_en
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    bridge_state_e     state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-3:0] adr_q;
    logic [3:0]        sel_q;
    logic              we_q;
    logic [31:0]       dat_q;

    logic              take_req;
    logic              mem_en_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_adr_d;
    logic [7:0]        mem_dat_d;
    logic              ack_d;

    logic              cap_en;
    logic [1:0]        cap_k;

    logic              unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:ADDR_W], wb_adr_i[1:0]};

    // Memory-side outputs are registered, so each state computes what the
    // memory port must show during the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take_req  = 1'b0;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        mem_adr_d = mem_adr;
        mem_dat_d = mem_dat_o;
        ack_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    take_req  = 1'b1;
                    state_d   = XFER;
                    cnt_d     = 2'd0;
                    mem_adr_d = {wb_adr_i[ADDR_W-1:2], 2'd0};
                    mem_en_d  = wb_sel_i[lane(2'd0)];
                    mem_we_d  = wb_we_i & wb_sel_i[lane(2'd0)];
                    mem_dat_d = wb_dat_i[8*lane(2'd0) +: 8];
                end
            end
            XFER: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_BYTE) begin
                    state_d = CAPT;
                end else begin
                    cnt_d     = cnt_q + 2'd1;
                    mem_adr_d = {adr_q, cnt_d};
                    mem_en_d  = sel_q[lane(cnt_d)];
                    mem_we_d  = we_q & sel_q[lane(cnt_d)];
                    mem_dat_d = dat_q[8*lane(cnt_d) +: 8];
                end
            end
            CAPT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after its byte was issued, so the lane being
    // filled trails the issue counter by one.
    always_comb begin
        cap_en = 1'b0;
        cap_k  = 2'd0;
        if (state_q == XFER && cnt_q != 2'd0) begin
            cap_en = 1'b1;
            cap_k  = cnt_q - 2'd1;
        end else if (state_q == CAPT) begin
            cap_en = 1'b1;
            cap_k  = LAST_BYTE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            adr_q     <= '0;
            sel_q     <= 4'd0;
            we_q      <= 1'b0;
            dat_q     <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_ack_o  <= 1'b0;
            mem_adr   <= '0;
            mem_dat_o <= 8'd0;
            mem_we    <= 1'b0;
            mem_en    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_ack_o  <= ack_d;
            mem_adr   <= mem_adr_d;
            mem_dat_o <= mem_dat_d;
            mem_we    <= mem_we_d;
            mem_en    <= mem_en_d;
            if (take_req) begin
                adr_q    <= wb_adr_i[ADDR_W-1:2];
                sel_q    <= wb_sel_i;
                we_q     <= wb_we_i;
                dat_q    <= wb_dat_i;
                wb_dat_o <= 32'd0;
            end else if (cap_en && !we_q && sel_q[lane(cap_k)]) begin
                wb_dat_o[8*lane(cap_k) +: 8] <= mem_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Self-checking bench for wb_mem_bridge: random and directed Wishbone accesses
// against a byte memory, with a queue-based scoreboard for acknowledged data.
module tb_wb_mem_bridge;

    localparam int ADDR_W   = 14;
    localparam int MEM_SIZE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_cyc_i = 1'b0;
    logic              wb_stb_i = 1'b0;
    logic              wb_we_i = 1'b0;
    logic [31:0]       wb_adr_i = 32'd0;
    logic [3:0]        wb_sel_i = 4'd0;
    logic [31:0]       wb_dat_i = 32'd0;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [ADDR_W-1:0] mem_adr;
    logic [7:0]        mem_dat_o;
    logic [7:0]        mem_dat_i;
    logic              mem_we;
    logic              mem_en;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]  phys_mem [MEM_SIZE];
    logic [7:0]  ref_mem  [MEM_SIZE];
    logic [7:0]  mem_rd;
    logic [31:0] exp_q [$];

    wb_mem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
        .mem_we(mem_we), .mem_en(mem_en)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM; read data is garbage whenever the port was idle.
    assign mem_dat_i = mem_rd;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys_mem[mem_adr] <= mem_dat_o;
            mem_rd <= phys_mem[mem_adr];
        end else begin
            mem_rd <= 8'($urandom);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_ack_o) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_ack", 32'd1, 32'd0);
            end else begin
                check_output("ack_data", wb_dat_o, exp_q.pop_front());
            end
        end
    end

    // Expected memory port activity for cycle c after the request edge.
    task automatic check_port(input int c, input logic we, input logic [ADDR_W-1:0] base,
                              input logic [3:0] sel, input logic [31:0] dat);
        int k;
        logic en;
        if (c <= 4) begin
            k  = c - 1;
            en = sel[3-k];
            check_output($sformatf("mem_en_c%0d", c), {31'd0, mem_en}, {31'd0, en});
            check_output($sformatf("mem_we_c%0d", c), {31'd0, mem_we}, {31'd0, en & we});
            if (en) begin
                check_output($sformatf("mem_adr_c%0d", c), 32'(mem_adr), 32'(base) + 32'(k));
                if (we) check_output($sformatf("mem_dat_c%0d", c), {24'd0, mem_dat_o},
                                     {24'd0, 8'(dat >> (8 * (3 - k)))});
            end
        end else begin
            check_output($sformatf("mem_en_c%0d", c), {31'd0, mem_en}, 32'd0);
            check_output($sformatf("mem_we_c%0d", c), {31'd0, mem_we}, 32'd0);
        end
        check_output($sformatf("ack_c%0d", c), {31'd0, wb_ack_o}, {31'd0, c == 6});
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
        check_output({tag, "_dat_o"}, wb_dat_o, 32'd0);
        check_output({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        check_output({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check_output({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
        check_output({tag, "_mem_dat"}, {24'd0, mem_dat_o}, 32'd0);
    endtask

    // mode 0: complete access; 1: cyc dropped before byte 2 is issued;
    // 2: reset asserted mid-cycle while byte 2 is on the memory port.
    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                  input logic [31:0] dat, input int mode);
        logic [31:0]       exp;
        logic [ADDR_W-1:0] base;
        int                last_c;
        base = {adr[ADDR_W-1:2], 2'b00};
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        if (mode == 0) begin
            exp = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (sel[3-k]) begin
                    if (we) ref_mem[base + ADDR_W'(k)] = 8'(dat >> (8 * (3 - k)));
                    else    exp |= {ref_mem[base + ADDR_W'(k)], 24'd0} >> (8 * k);
                end
            end
            exp_q.push_back(exp);
        end else if (mode == 1 && we) begin
            for (int k = 0; k < 2; k++)
                if (sel[3-k]) ref_mem[base + ADDR_W'(k)] = 8'(dat >> (8 * (3 - k)));
        end
        @(posedge clk);
        last_c = (mode == 0) ? 6 : ((mode == 1) ? 2 : 3);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            check_port(c, we, base, sel, dat);
            if (mode == 1 && c == 1) begin
                @(posedge clk);
                #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
        if (mode == 0) begin
            @(posedge clk);
            #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end else if (mode == 1) begin
            for (int c = 3; c <= 7; c++) begin
                @(negedge clk);
                check_output($sformatf("abort_mem_en_c%0d", c), {31'd0, mem_en}, 32'd0);
                check_output($sformatf("abort_ack_c%0d", c), {31'd0, wb_ack_o}, 32'd0);
            end
            @(posedge clk);
            #1;
        end else begin
            #1 rst = 1'b1;
            #1 check_all_zero("midreset");
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check_output("post_reset_mem_en", {31'd0, mem_en}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          diffs;
        for (int i = 0; i < MEM_SIZE; i++) begin
            phys_mem[i] = 8'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        mem_rd = 8'd0;

        #3 check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_output("idle_mem_en", {31'd0, mem_en}, 32'd0);
        end
        @(posedge clk);
        #1;

        apply_stimulus(1'b1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 0);
        apply_stimulus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 0);
        apply_stimulus(1'b0, 32'h0000_2000, 4'b0100, 32'h0, 0);
        apply_stimulus(1'b1, 32'h0000_0100, 4'b1111, 32'h1122_3344, 1);
        apply_stimulus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 0);
        apply_stimulus(1'b1, 32'h0000_0104, 4'b0000, 32'hCAFE_F00D, 0);
        apply_stimulus(1'b0, 32'h0000_2000, 4'b0000, 32'h0, 0);
        apply_stimulus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 2);
        apply_stimulus(1'b0, 32'hFFFF_E003, 4'b1001, 32'h0, 0);

        // Random traffic in a small window so reads revisit earlier writes;
        // stray high and low address bits must be ignored.
        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            a[ADDR_W-1:2] = 12'h800 + 12'($urandom_range(0, 15));
            apply_stimulus(1'($urandom), a, 4'($urandom), $urandom(), 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        check_output("pending_acks", 32'(exp_q.size()), 32'd0);
        diffs = 0;
        for (int i = 0; i < MEM_SIZE; i++)
            if (phys_mem[i] !== ref_mem[i]) diffs++;
        check_output("mem_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
